// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter with frame sequencing, baud timing, LSB-first
// data shifting, optional parity bit and a ready/done handshake.
// Optional feature macro: UART_TX_PARITY_EN adds one parity bit per frame
// (even/odd chosen by parity_odd when the frame is accepted).
// tx, tx_busy and tx_done are registered from the sequencer state, so the
// line follows the internal state by one clock; tx_ready is combinational.

module uart_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              parity_odd,
  output logic              tx,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W) + 1;

  localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(1'b0);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1'b1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = BIT_W'(1'b0);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1'b1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state_r, state_nxt_s;
  logic [BAUD_W-1:0] baud_r, baud_nxt_s;
  logic [BIT_W-1:0]  bit_r, bit_nxt_s;
  logic [DATA_W-1:0] shift_r, shift_nxt_s;
  logic              tx_r, tx_nxt_s;
  logic              busy_r;
  logic              stop_end_r;
  logic              done_r;
  logic              bit_end_s;
  logic              last_stop_s;
  logic              accept_s;

`ifdef UART_TX_PARITY_EN
  logic parity_r, parity_nxt_s;

  // Parity bit: XOR of all payload bits, inverted for odd parity.
  function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
`else
  logic unused_parity_s;
  assign unused_parity_s = parity_odd;
`endif

  assign bit_end_s   = (baud_r == BAUD_LAST);
  assign last_stop_s = (state_r == S_STOP) && bit_end_s && (bit_r == STOP_LAST);
  assign tx_ready    = (state_r == S_IDLE) || last_stop_s;
  assign accept_s    = tx_start && tx_ready;

  // Baud counter: free-runs 0..CLKS_PER_BIT-1 while a frame is in flight.
  always_comb begin
    baud_nxt_s = baud_r;
    if ((state_r == S_IDLE) || bit_end_s) begin
      baud_nxt_s = BAUD_ZERO;
    end else begin
      baud_nxt_s = baud_r + BAUD_ONE;
    end
  end

  // Frame sequencer: accept loads a new frame, otherwise advance on bit_end.
  always_comb begin
    state_nxt_s  = state_r;
    bit_nxt_s    = bit_r;
    shift_nxt_s  = shift_r;
`ifdef UART_TX_PARITY_EN
    parity_nxt_s = parity_r;
`endif
    if (accept_s) begin
      state_nxt_s  = S_START;
      bit_nxt_s    = BIT_ZERO;
      shift_nxt_s  = tx_data;
`ifdef UART_TX_PARITY_EN
      parity_nxt_s = calc_parity(tx_data, parity_odd);
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          state_nxt_s = S_IDLE;
        end
        S_START: begin
          if (bit_end_s) begin
            state_nxt_s = S_DATA;
            bit_nxt_s   = BIT_ZERO;
          end else begin
            state_nxt_s = S_START;
          end
        end
        S_DATA: begin
          if (bit_end_s) begin
            shift_nxt_s = {1'b0, shift_r[DATA_W-1:1]};
            if (bit_r == DATA_LAST) begin
              bit_nxt_s = BIT_ZERO;
`ifdef UART_TX_PARITY_EN
              state_nxt_s = S_PARITY;
`else
              state_nxt_s = S_STOP;
`endif
            end else begin
              bit_nxt_s = bit_r + BIT_ONE;
            end
          end else begin
            state_nxt_s = S_DATA;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end_s) begin
            state_nxt_s = S_STOP;
            bit_nxt_s   = BIT_ZERO;
          end else begin
            state_nxt_s = S_PARITY;
          end
        end
`endif
        S_STOP: begin
          if (bit_end_s) begin
            if (bit_r == STOP_LAST) begin
              state_nxt_s = S_IDLE;
              bit_nxt_s   = BIT_ZERO;
            end else begin
              bit_nxt_s = bit_r + BIT_ONE;
            end
          end else begin
            state_nxt_s = S_STOP;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
          bit_nxt_s   = BIT_ZERO;
        end
      endcase
    end
  end

  // Line value for the current state, registered below for a glitch-free pin.
  always_comb begin
    tx_nxt_s = 1'b1;
    case (state_r)
      S_IDLE:   tx_nxt_s = 1'b1;
      S_START:  tx_nxt_s = 1'b0;
      S_DATA:   tx_nxt_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_nxt_s = parity_r;
`endif
      S_STOP:   tx_nxt_s = 1'b1;
      default:  tx_nxt_s = 1'b1;
    endcase
  end

  // State, counters, data path and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      baud_r     <= BAUD_ZERO;
      bit_r      <= BIT_ZERO;
      shift_r    <= {DATA_W{1'b0}};
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      stop_end_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      baud_r     <= baud_nxt_s;
      bit_r      <= bit_nxt_s;
      shift_r    <= shift_nxt_s;
      tx_r       <= tx_nxt_s;
      busy_r     <= (state_r != S_IDLE);
      stop_end_r <= last_stop_s;
      done_r     <= stop_end_r;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity bit latched together with the payload on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= parity_nxt_s;
    end
  end
`endif

  assign tx      = tx_r;
  assign tx_busy = busy_r;
  assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame. Frames are described as bit lists
// (start, payload LSB first, optional parity, stop bits); a scoreboard queue
// links accepted requests to the frames observed on the line.

module tb_uart_tx_frame;

  localparam int DW  = 8;
  localparam int SB  = 2;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int NBITS = 1 + DW + PB + SB;
  localparam int L     = NBITS * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tx_start = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          parity_odd = 1'b0;
  logic          tx, tx_ready, tx_busy, tx_done;

  uart_tx_frame #(.DATA_W(DW), .STOP_BITS(SB), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .parity_odd(parity_odd), .tx(tx), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int unsigned ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [NBITS-1:0] exp_bits_q[$];
  int unsigned      exp_acc_q[$];

  // Reference model state: start edge of the most recent accepted frame.
  logic        m_active = 1'b0;
  int unsigned m_start  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, ecount);
    end
  endtask

  function automatic logic [NBITS-1:0] model_frame(input logic [DW-1:0] d, input logic odd);
    logic [NBITS-1:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DW; i++) begin
      f[1+i] = d[i];
      if (d[i]) ones++;
    end
    if (PB == 1) f[1+DW] = ((ones % 2) == 1) ^ odd;
    return f;
  endfunction

  function automatic logic model_ready(input int unsigned e);
    return !m_active || (e >= m_start + L - 1);
  endfunction

  // One clock of stimulus; entered and left at a falling edge.
  task automatic cycle_drive(input logic start, input logic [DW-1:0] d, input logic odd,
                             output logic accepted);
    logic mr;
    mr = model_ready(ecount);
    check("tx_ready", tx_ready, mr);
    tx_start   = start;
    tx_data    = d;
    parity_odd = odd;
    accepted   = start && mr;
    if (accepted) begin
      exp_bits_q.push_back(model_frame(d, odd));
      exp_acc_q.push_back(ecount + 1);
      m_active = 1'b1;
      m_start  = ecount + 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle_drive(1'b0, DW'($urandom), 1'b0, a);
  endtask

  // Hold tx_start until the model says the request is taken.
  task automatic send(input logic [DW-1:0] d, input logic odd);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 4 * L && !a; i++) cycle_drive(1'b1, d, odd, a);
    check("send_accept", a, 1'b1);
  endtask

  // Monitor: rebuilds frames from the line and checks them against the queue.
  initial begin
    logic             in_frame;
    int               cnt;
    int unsigned      start_cyc;
    int unsigned      done_due;
    logic [NBITS-1:0] got, expf;
    int unsigned      acc;
    logic             hold_ok, busy_ok;
    in_frame = 1'b0; cnt = 0; start_cyc = 0; done_due = 0; got = '0;
    hold_ok = 1'b1; busy_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
        done_due = 0;
      end else begin
        if (tx_done || (ecount == done_due)) check("done_pulse", tx_done, ecount == done_due);
        if (!in_frame && tx == 1'b0) begin
          in_frame = 1'b1; cnt = 0; start_cyc = ecount;
          hold_ok = 1'b1; busy_ok = 1'b1; got = '0;
        end
        if (in_frame) begin
          if (cnt % CPB == 0) got[cnt / CPB] = tx;
          else if (tx !== got[cnt / CPB]) hold_ok = 1'b0;
          if (tx_busy !== 1'b1) busy_ok = 1'b0;
          cnt++;
          if (cnt == L) begin
            in_frame = 1'b0;
            done_due = ecount + 1;
            check("frame_expected", exp_bits_q.size() != 0, 1'b1);
            if (exp_bits_q.size() != 0) begin
              expf = exp_bits_q.pop_front();
              acc  = exp_acc_q.pop_front();
              check("frame_bits", got, expf);
              check("frame_start_edge", start_cyc, acc + 1);
              check("bit_hold", hold_ok, 1'b1);
              check("busy_in_frame", busy_ok, 1'b1);
            end
          end
        end else begin
          check("busy_idle", tx_busy, 1'b0);
        end
      end
    end
  end

  initial begin
    logic a;
    // Reset held for three clocks.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_done", tx_done, 1'b0);
      check("rst_ready", tx_ready, 1'b1);
    end
    rst_n = 1'b1;
    idle(3);

    // Single frames.
    send(8'hA5, 1'b0);
    idle(L + 5);
    send(8'h01, 1'b1);
    idle(L + 5);

    // Back-to-back with tx_start held high.
    send(8'h55, 1'b0);
    send(8'h0F, 1'b1);
    idle(L + 5);

    // Start request in the middle of a data bit is ignored.
    send(8'h00, 1'b0);
    while (ecount < m_start + 1 + 3 * CPB + 1) idle(1);
    cycle_drive(1'b1, 8'hFF, 1'b1, a);
    idle(L + 5);

    // Reset during data bit 3 of a 0x00 frame (line is low there).
    send(8'h00, 1'b0);
    while (ecount < m_start + 1 + 4 * CPB + 1) idle(1);
    check("pre_reset_tx", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_busy", tx_busy, 1'b0);
    check("async_rst_done", tx_done, 1'b0);
    exp_bits_q.delete();
    exp_acc_q.delete();
    m_active = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(L + 5);
    send(8'hC3, 1'b1);
    idle(L + 5);

    // Randomized traffic, including requests while busy.
    for (int i = 0; i < 400; i++) begin
      cycle_drive(($urandom % 4) == 0, DW'($urandom), 1'($urandom), a);
    end

    // Drain outstanding frames with a bounded wait.
    for (int i = 0; i < 4 * L && exp_bits_q.size() != 0; i++) idle(1);
    check("drain_empty", exp_bits_q.size(), 0);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
